wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 27 ++
 rtl/wb_stage_load_align.sv | 49 ++++
 rtl/wb_stage.sv | 170 +++++++++++++++++
 tb/tb_wb_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_pkg
//  Description : Shared CPU definitions for the write-back stage.
//                Holds the load-size encodings, the link register index and
//                the link-buffer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_stage_pkg;

    // MemRead_mem encodings
    localparam logic [1:0] MEMREAD_NONE = 2'b00;
    localparam logic [1:0] MEMREAD_WORD = 2'b01;
    localparam logic [1:0] MEMREAD_BYTE = 2'b10;
    localparam logic [1:0] MEMREAD_HALF = 2'b11;

    // Register written by jump-and-link
    localparam int JAL_REG_IDX = 31;

    // One-entry link-write buffer
    typedef enum logic [0:0] {
        BUF_EMPTY = 1'b0,
        BUF_HELD  = 1'b1
    } buf_state_e;

endpackage : wb_stage_pkg
`default_nettype wire

// File: rtl/wb_stage_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load extractor. Selects the byte / halfword
//                addressed by the low address bits and sign-extends it.
//  Ports       : mem_read  [1:0]  load size (00 none, 01 word, 10 byte, 11 half)
//                offset    [1:0]  byte offset within the word
//                rdata     [DW]   raw memory word
//                load_data [DW]   aligned, extended result
//  Revision    : 1.0  initial release
// ============================================================================
module load_align
    import wb_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    mem_read,
    input  logic [1:0]    offset,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        // offset[0] on a half load is a misalignment; it is ignored and the
        // half selected by offset[1] is returned without trapping.
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        load_data = rdata;
        case (mem_read)
            MEMREAD_BYTE: load_data = {{(DW-8){byte_sel[7]}}, byte_sel};
            MEMREAD_HALF: load_data = {{(DW-16){half_sel[15]}}, half_sel};
            MEMREAD_WORD: load_data = rdata;
            default:      load_data = rdata;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : MEM/WB pipeline register and write-back selection, with a
//                dedicated link-register write port. A link write that lands
//                in the same cycle as a normal write to the link register is
//                parked in a one-entry buffer and issued the following cycle.
//  Ports       : clk, reset (async, active-low)
//                stall / flush          stage register control
//                *_mem                  MEM-stage instruction fields
//                jal_req, jal_wdata_in  link-write request and value
//                RegWrite_wb, rd_wb, data_wb   register-file write port
//                jal_en, jal_wdata      link write port
//                wb_busy                link buffer occupied
//  Revision    : 1.0  initial release
// ============================================================================
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DW      = 32,
    parameter int RW      = 5,
    parameter int JAL_REG = JAL_REG_IDX
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          valid_mem,
    input  logic          RegWrite_mem,
    input  logic          MemtoReg_mem,
    input  logic [1:0]    MemRead_mem,
    input  logic [RW-1:0] rd_mem,
    input  logic [DW-1:0] Aluout_mem,
    input  logic [DW-1:0] Rdata_mem,
    input  logic          jal_req,
    input  logic [DW-1:0] jal_wdata_in,
    output logic          RegWrite_wb,
    output logic [RW-1:0] rd_wb,
    output logic [DW-1:0] data_wb,
    output logic          jal_en,
    output logic [DW-1:0] jal_wdata,
    output logic          wb_busy
);

    // ---------------------------------------------------------------- stage
    logic          valid_q,      valid_d;
    logic          reg_write_q,  reg_write_d;
    logic          mem_to_reg_q, mem_to_reg_d;
    logic [1:0]    mem_read_q,   mem_read_d;
    logic [RW-1:0] rd_q,         rd_d;
    logic [DW-1:0] alu_out_q,    alu_out_d;
    logic [DW-1:0] rdata_q,      rdata_d;

    // ----------------------------------------------------------------- link
    buf_state_e    buf_state_q,  buf_state_d;
    logic [DW-1:0] buf_data_q,   buf_data_d;
    logic          jal_en_q,     jal_en_d;
    logic [DW-1:0] jal_wdata_q,  jal_wdata_d;

    logic          jal_accept;
    logic          next_writes_link;
    logic [DW-1:0] load_data;

    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        mem_read_d   = mem_read_q;
        rd_d         = rd_q;
        alu_out_d    = alu_out_q;
        rdata_d      = rdata_q;

        // flush wins over stall: a flushed slot always becomes a bubble
        if (!stall || flush) begin
            valid_d      = valid_mem;
            reg_write_d  = RegWrite_mem;
            mem_to_reg_d = MemtoReg_mem;
            mem_read_d   = MemRead_mem;
            rd_d         = rd_mem;
            alu_out_d    = Aluout_mem;
            rdata_d      = Rdata_mem;
        end
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end
    end

    // Collision is judged against the write the stage will present next
    // cycle, which is the same cycle the link write would issue.
    assign next_writes_link = valid_d && reg_write_d && (rd_d == RW'(JAL_REG));
    assign jal_accept       = jal_req && (buf_state_q == BUF_EMPTY);

    always_comb begin
        buf_state_d = buf_state_q;
        buf_data_d  = buf_data_q;
        jal_en_d    = 1'b0;
        jal_wdata_d = jal_wdata_q;

        case (buf_state_q)
            BUF_EMPTY: begin
                if (jal_accept) begin
                    if (next_writes_link) begin
                        buf_state_d = BUF_HELD;
                        buf_data_d  = jal_wdata_in;
                    end else begin
                        jal_en_d    = 1'b1;
                        jal_wdata_d = jal_wdata_in;
                    end
                end
            end
            BUF_HELD: begin
                // New requests are refused while held, so the buffered write
                // always issues before any younger link write.
                if (!next_writes_link) begin
                    jal_en_d    = 1'b1;
                    jal_wdata_d = buf_data_q;
                    buf_state_d = BUF_EMPTY;
                end
            end
            default: buf_state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_read_q   <= MEMREAD_NONE;
            rd_q         <= '0;
            alu_out_q    <= '0;
            rdata_q      <= '0;
            buf_state_q  <= BUF_EMPTY;
            buf_data_q   <= '0;
            jal_en_q     <= 1'b0;
            jal_wdata_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_read_q   <= mem_read_d;
            rd_q         <= rd_d;
            alu_out_q    <= alu_out_d;
            rdata_q      <= rdata_d;
            buf_state_q  <= buf_state_d;
            buf_data_q   <= buf_data_d;
            jal_en_q     <= jal_en_d;
            jal_wdata_q  <= jal_wdata_d;
        end
    end

    load_align #(
        .DW (DW)
    ) u_load_align (
        .mem_read  (mem_read_q),
        .offset    (alu_out_q[1:0]),
        .rdata     (rdata_q),
        .load_data (load_data)
    );

    assign RegWrite_wb = valid_q && reg_write_q && (rd_q != '0);
    assign rd_wb       = rd_q;
    assign data_wb     = mem_to_reg_q ? load_data : alu_out_q;
    assign jal_en      = jal_en_q;
    assign jal_wdata   = jal_wdata_q;
    assign wb_busy     = (buf_state_q == BUF_HELD);

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Directed self-checking bench for wb_stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        valid_mem;
    logic        RegWrite_mem;
    logic        MemtoReg_mem;
    logic [1:0]  MemRead_mem;
    logic [4:0]  rd_mem;
    logic [31:0] Aluout_mem;
    logic [31:0] Rdata_mem;
    logic        jal_req;
    logic [31:0] jal_wdata_in;
    logic        RegWrite_wb;
    logic [4:0]  rd_wb;
    logic [31:0] data_wb;
    logic        jal_en;
    logic [31:0] jal_wdata;
    logic        wb_busy;

    int n_pass  = 0;
    int n_total = 0;

    wb_stage u_dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .valid_mem    (valid_mem),
        .RegWrite_mem (RegWrite_mem),
        .MemtoReg_mem (MemtoReg_mem),
        .MemRead_mem  (MemRead_mem),
        .rd_mem       (rd_mem),
        .Aluout_mem   (Aluout_mem),
        .Rdata_mem    (Rdata_mem),
        .jal_req      (jal_req),
        .jal_wdata_in (jal_wdata_in),
        .RegWrite_wb  (RegWrite_wb),
        .rd_wb        (rd_wb),
        .data_wb      (data_wb),
        .jal_en       (jal_en),
        .jal_wdata    (jal_wdata),
        .wb_busy      (wb_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_mem(input logic v, input logic rw, input logic m2r,
                           input logic [1:0] mr, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] rdat);
        valid_mem    = v;
        RegWrite_mem = rw;
        MemtoReg_mem = m2r;
        MemRead_mem  = mr;
        rd_mem       = rd;
        Aluout_mem   = alu;
        Rdata_mem    = rdat;
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        jal_req = 1'b1; jal_wdata_in = 32'h1111_2222;
        set_mem(1'b1, 1'b1, 1'b1, 2'b01, 5'd7, 32'h5555_5555, 32'h6666_6666);
        #2;
        chk("rst_regwrite", {31'd0, RegWrite_wb}, 32'd0);
        tick(); tick();
        chk("rst_regwrite_clk", {31'd0, RegWrite_wb}, 32'd0);
        chk("rst_rd",           {27'd0, rd_wb},       32'd0);
        chk("rst_data",         data_wb,              32'd0);
        chk("rst_jal_en",       {31'd0, jal_en},      32'd0);
        chk("rst_jal_wdata",    jal_wdata,            32'd0);
        chk("rst_busy",         {31'd0, wb_busy},     32'd0);
        jal_req = 1'b0;
        reset = 1'b1;

        // signed byte load, offset 1
        set_mem(1'b1, 1'b1, 1'b1, 2'b10, 5'd8, 32'h0000_1001, 32'h0000_80FF);
        #1;
        chk("latency_before_edge", data_wb, 32'd0);
        tick();
        chk("byte_regwrite", {31'd0, RegWrite_wb}, 32'd1);
        chk("byte_rd",       {27'd0, rd_wb},       32'd8);
        chk("byte_data",     data_wb,              32'hFFFF_FF80);

        set_mem(1'b1, 1'b1, 1'b1, 2'b11, 5'd9, 32'h0000_2002, 32'h7FFF_0001);
        tick();
        chk("half_hi_data", data_wb, 32'h0000_7FFF);

        set_mem(1'b1, 1'b1, 1'b1, 2'b11, 5'd9, 32'h0000_2001, 32'h1234_8001);
        tick();
        chk("half_misaligned_lo", data_wb, 32'hFFFF_8001);

        set_mem(1'b1, 1'b1, 1'b1, 2'b11, 5'd9, 32'h0000_2003, 32'h7FFF_0001);
        tick();
        chk("half_misaligned_hi", data_wb, 32'h0000_7FFF);

        set_mem(1'b1, 1'b1, 1'b1, 2'b10, 5'd10, 32'h0000_0003, 32'h7F00_00FF);
        tick();
        chk("byte_off3", data_wb, 32'h0000_007F);

        set_mem(1'b1, 1'b1, 1'b1, 2'b10, 5'd10, 32'h0000_0000, 32'h7F00_00FF);
        tick();
        chk("byte_off0", data_wb, 32'hFFFF_FFFF);

        set_mem(1'b1, 1'b1, 1'b1, 2'b01, 5'd11, 32'h0000_0002, 32'hDEAD_BEEF);
        tick();
        chk("word_data", data_wb, 32'hDEAD_BEEF);

        set_mem(1'b1, 1'b1, 1'b1, 2'b00, 5'd12, 32'h0000_0001, 32'hCAFE_F00D);
        tick();
        chk("none_memtoreg", data_wb, 32'hCAFE_F00D);

        set_mem(1'b1, 1'b1, 1'b0, 2'b10, 5'd13, 32'h1234_5678, 32'hCAFE_F00D);
        tick();
        chk("alu_data", data_wb,              32'h1234_5678);
        chk("alu_rd",   {27'd0, rd_wb},       32'd13);

        set_mem(1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 32'h0000_1234, 32'h0);
        tick();
        chk("r0_no_write", {31'd0, RegWrite_wb}, 32'd0);

        set_mem(1'b0, 1'b1, 1'b0, 2'b00, 5'd14, 32'h0000_4321, 32'h0);
        tick();
        chk("invalid_no_write", {31'd0, RegWrite_wb}, 32'd0);

        // stall holds the stage for three cycles
        set_mem(1'b1, 1'b1, 1'b0, 2'b00, 5'd15, 32'hA5A5_0F0F, 32'h0);
        tick();
        stall = 1'b1;
        set_mem(1'b1, 1'b1, 1'b0, 2'b00, 5'd16, 32'h0BAD_0BAD, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_data",     data_wb,              32'hA5A5_0F0F);
            chk("stall_rd",       {27'd0, rd_wb},       32'd15);
            chk("stall_regwrite", {31'd0, RegWrite_wb}, 32'd1);
        end
        flush = 1'b1;
        tick();
        chk("flush_over_stall", {31'd0, RegWrite_wb}, 32'd0);
        flush = 1'b0; stall = 1'b0;

        // plain link write
        set_mem(1'b1, 1'b1, 1'b0, 2'b00, 5'd5, 32'h0000_0005, 32'h0);
        jal_req = 1'b1; jal_wdata_in = 32'h0000_0100;
        tick();
        chk("jal_en",       {31'd0, jal_en},      32'd1);
        chk("jal_wdata",    jal_wdata,            32'h0000_0100);
        chk("jal_busy",     {31'd0, wb_busy},     32'd0);
        chk("jal_normal",   {31'd0, RegWrite_wb}, 32'd1);
        jal_req = 1'b0;
        tick();
        chk("jal_en_drop", {31'd0, jal_en}, 32'd0);

        // collision
        set_mem(1'b1, 1'b1, 1'b0, 2'b00, 5'd31, 32'hAAAA_0000, 32'h0);
        jal_req = 1'b1; jal_wdata_in = 32'h0040_0008;
        tick();
        chk("col1_regwrite", {31'd0, RegWrite_wb}, 32'd1);
        chk("col1_rd",       {27'd0, rd_wb},       32'd31);
        chk("col1_jal_en",   {31'd0, jal_en},      32'd0);
        chk("col1_busy",     {31'd0, wb_busy},     32'd1);
        jal_req = 1'b0;
        set_mem(1'b1, 1'b1, 1'b0, 2'b00, 5'd3, 32'h0000_0003, 32'h0);
        tick();
        chk("col2_jal_en",    {31'd0, jal_en},  32'd1);
        chk("col2_jal_wdata", jal_wdata,        32'h0040_0008);
        chk("col2_busy",      {31'd0, wb_busy}, 32'd0);

        // persisting collision, younger request held upstream, then ordering
        set_mem(1'b1, 1'b1, 1'b0, 2'b00, 5'd31, 32'h0000_0031, 32'h0);
        jal_req = 1'b1; jal_wdata_in = 32'h0000_0011;
        tick();
        chk("pers1_busy", {31'd0, wb_busy}, 32'd1);
        jal_wdata_in = 32'h0000_0022;
        tick();
        chk("pers2_busy",   {31'd0, wb_busy}, 32'd1);
        chk("pers2_jal_en", {31'd0, jal_en},  32'd0);
        set_mem(1'b1, 1'b1, 1'b0, 2'b00, 5'd4, 32'h0000_0004, 32'h0);
        tick();
        chk("order1_jal_en",    {31'd0, jal_en},  32'd1);
        chk("order1_jal_wdata", jal_wdata,        32'h0000_0011);
        chk("order1_busy",      {31'd0, wb_busy}, 32'd0);
        tick();
        chk("order2_jal_en",    {31'd0, jal_en}, 32'd1);
        chk("order2_jal_wdata", jal_wdata,       32'h0000_0022);
        jal_req = 1'b0;

        // flush does not drop a buffered link write
        set_mem(1'b1, 1'b1, 1'b0, 2'b00, 5'd31, 32'h0000_0131, 32'h0);
        jal_req = 1'b1; jal_wdata_in = 32'h0000_0033;
        tick();
        chk("flushbuf_busy", {31'd0, wb_busy}, 32'd1);
        jal_req = 1'b0; flush = 1'b1;
        tick();
        chk("flushbuf_regwrite", {31'd0, RegWrite_wb}, 32'd0);
        chk("flushbuf_jal_en",   {31'd0, jal_en},      32'd1);
        chk("flushbuf_wdata",    jal_wdata,            32'h0000_0033);
        flush = 1'b0;

        // asynchronous reset while held
        set_mem(1'b1, 1'b1, 1'b0, 2'b00, 5'd31, 32'h0000_0231, 32'h0);
        jal_req = 1'b1; jal_wdata_in = 32'h0000_0044;
        tick();
        chk("arst_pre_busy", {31'd0, wb_busy}, 32'd1);
        jal_req = 1'b0;
        set_mem(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy",     {31'd0, wb_busy},     32'd0);
        chk("arst_jal_en",   {31'd0, jal_en},      32'd0);
        chk("arst_regwrite", {31'd0, RegWrite_wb}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("arst_buf_dropped", {31'd0, jal_en},  32'd0);
        chk("arst_busy_after",  {31'd0, wb_busy}, 32'd0);

        set_mem(1'b1, 1'b1, 1'b0, 2'b00, 5'd6, 32'h0000_0666, 32'h0);
        tick();
        chk("post_rst_data",     data_wb,              32'h0000_0666);
        chk("post_rst_regwrite", {31'd0, RegWrite_wb}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_wb_stage
`default_nettype wire
